// File: rtl/audio_fifo_streamer_pkg.sv
// -----------------------------------------------------------------------------
// audio_fifo_pkg
// Shared definitions for the audio FIFO streamer: the playback state encoding
// and the default values of every block parameter.
// -----------------------------------------------------------------------------
package audio_fifo_pkg;

  localparam int AFS_DATA_W     = 16;   // bits per channel sample
  localparam int AFS_NUM_CH     = 2;    // channels per frame
  localparam int AFS_DEPTH_LOG2 = 11;   // FIFO holds 2^DEPTH_LOG2 frames
  localparam int AFS_DIV_W      = 32;   // sample-period divider width
  localparam int AFS_START_LVL  = 4;    // frames buffered before playback starts
  localparam int AFS_LOW_WM     = 256;  // low-watermark level for the interrupt

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } afs_state_e;

endpackage

// File: rtl/audio_fifo_streamer_if.sv
// -----------------------------------------------------------------------------
// audio_fifo_streamer_if
// Bundles the frame-write, playback-control and status signals of the
// streamer. The master modport is the producer/controller side, the slave
// modport is the streamer itself.
//   wr_data/wr_req      frame push (channel 0 in the LSBs)
//   div_freq            sample period in clock cycles (0 behaves as 1)
//   pause/stop          playback control (pause is a level, stop a pulse)
//   out_data/out_valid  current output frame and its update strobe
//   fifo_*              occupancy and full/empty status
//   underflow/overflow  sticky error flags
//   low_wm_irq          one-cycle low-watermark interrupt
// -----------------------------------------------------------------------------
interface audio_fifo_streamer_if
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W     = AFS_DATA_W,
  parameter int NUM_CH     = AFS_NUM_CH,
  parameter int DEPTH_LOG2 = AFS_DEPTH_LOG2,
  parameter int DIV_W      = AFS_DIV_W
);

  logic [NUM_CH*DATA_W-1:0] wr_data;
  logic                     wr_req;
  logic [DIV_W-1:0]         div_freq;
  logic                     pause;
  logic                     stop;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     out_valid;
  logic [DEPTH_LOG2:0]      fifo_used;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     underflow;
  logic                     overflow;
  logic                     low_wm_irq;

  modport master (
    output wr_data, wr_req, div_freq, pause, stop,
    input  out_data, out_valid, fifo_used, fifo_full, fifo_empty,
           underflow, overflow, low_wm_irq
  );

  modport slave (
    input  wr_data, wr_req, div_freq, pause, stop,
    output out_data, out_valid, fifo_used, fifo_full, fifo_empty,
           underflow, overflow, low_wm_irq
  );

endinterface

// File: rtl/afs_frame_fifo.sv
// -----------------------------------------------------------------------------
// afs_frame_fifo
// Frame storage for the streamer: a 2^DEPTH_LOG2-entry circular buffer with
// wrapping read/write pointers and an occupancy counter.
//   clk, rst    clock, asynchronous active-high reset
//   i_flush     synchronous discard of all contents
//   i_push      write i_wr_data (caller guarantees not full)
//   i_pop       advance the head (caller guarantees not empty)
//   o_head      frame at the head of the queue
//   o_used      frames stored, 0..2^DEPTH_LOG2
//   o_full      o_used == 2^DEPTH_LOG2
//   o_empty     o_used == 0
// -----------------------------------------------------------------------------
module afs_frame_fifo
  import audio_fifo_pkg::*;
#(
  parameter int FRAME_W    = AFS_NUM_CH * AFS_DATA_W,
  parameter int DEPTH_LOG2 = AFS_DEPTH_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [FRAME_W-1:0]   i_wr_data,
  output logic [FRAME_W-1:0]   o_head,
  output logic [DEPTH_LOG2:0]  o_used,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [FRAME_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_used;

  // Storage carries no reset: stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers are exactly DEPTH_LOG2 bits so they wrap modulo the depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({i_push, i_pop})
        2'b10:   r_used <= r_used + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_used <= r_used - (DEPTH_LOG2 + 1)'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_used  = r_used;
  // The count never exceeds DEPTH, so its MSB alone marks full.
  assign o_full  = r_used[DEPTH_LOG2];
  assign o_empty = (r_used == '0);

endmodule

// File: rtl/audio_fifo_streamer.sv
// -----------------------------------------------------------------------------
// audio_fifo_streamer
// Buffers multichannel audio frames and replays them at a programmable
// sample rate. Playback waits in IDLE until START_LVL frames are buffered,
// then a divider emits one frame every max(div_freq,1) cycles while in RUN.
//   clk_clk      sole clock, rising edge
//   reset_reset  asynchronous active-high reset
//   bus          audio_fifo_streamer_if.slave (push, control, output, status)
// The interface instance must use the same DATA_W/NUM_CH/DEPTH_LOG2/DIV_W.
// -----------------------------------------------------------------------------
module audio_fifo_streamer
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W     = AFS_DATA_W,
  parameter int NUM_CH     = AFS_NUM_CH,
  parameter int DEPTH_LOG2 = AFS_DEPTH_LOG2,
  parameter int DIV_W      = AFS_DIV_W,
  parameter int START_LVL  = AFS_START_LVL,
  parameter int LOW_WM     = AFS_LOW_WM
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  audio_fifo_streamer_if.slave  bus
);

  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int USED_W  = DEPTH_LOG2 + 1;
  localparam logic [USED_W-1:0] START_LVL_C = USED_W'(START_LVL);
  localparam logic [USED_W-1:0] LOW_WM_C    = USED_W'(LOW_WM);

  afs_state_e          r_state;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [DIV_W-1:0]    w_div_max;
  logic                w_tick;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [FRAME_W-1:0]  w_head;
  logic [USED_W-1:0]   w_used;
  logic [FRAME_W-1:0]  r_out_data_p1;
  logic                r_vld_p1;
  logic                r_underflow;
  logic                r_overflow;
  logic                r_low_wm_irq;

  // A period of 0 behaves like 1: tick every RUN cycle.
  assign w_div_max = (bus.div_freq == '0) ? '0 : bus.div_freq - DIV_W'(1);
  // ">=" rather than "==" so a lowered div_freq ticks on the next cycle.
  assign w_tick    = (r_state == ST_RUN) && (r_div_cnt >= w_div_max) && !bus.stop;
  assign w_push    = bus.wr_req && !w_full && !bus.stop;
  // Emptiness is the registered view, so a push landing on a tick cycle
  // cannot satisfy that tick.
  assign w_pop     = w_tick && !w_empty;

  afs_frame_fifo #(
    .FRAME_W    (FRAME_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk_clk),
    .rst        (reset_reset),
    .i_flush    (bus.stop),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_wr_data  (bus.wr_data),
    .o_head     (w_head),
    .o_used     (w_used),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state <= ST_IDLE;
    end else if (bus.stop) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_used >= START_LVL_C && !bus.pause) r_state <= ST_RUN;
        ST_RUN:    if (bus.pause)  r_state <= ST_PAUSED;
        ST_PAUSED: if (!bus.pause) r_state <= ST_RUN;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Divider counts in RUN, holds in PAUSED, clears in IDLE.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_div_cnt <= '0;
    end else if (bus.stop || r_state == ST_IDLE) begin
      r_div_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  // Output stage: popped frame and status flags visible one cycle after the tick.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_out_data_p1 <= '0;
      r_vld_p1      <= 1'b0;
      r_underflow   <= 1'b0;
      r_overflow    <= 1'b0;
      r_low_wm_irq  <= 1'b0;
    end else begin
      r_vld_p1     <= w_pop;
      // Occupancy only drops one frame at a time, so crossing below the
      // watermark means a lone pop at exactly LOW_WM.
      r_low_wm_irq <= w_pop && !w_push && (w_used == LOW_WM_C);
      if (bus.stop) begin
        r_out_data_p1 <= '0;
        r_underflow   <= 1'b0;
        r_overflow    <= 1'b0;
      end else begin
        if (w_pop)                r_out_data_p1 <= w_head;
        if (w_tick && w_empty)    r_underflow   <= 1'b1;
        if (bus.wr_req && w_full) r_overflow    <= 1'b1;
      end
    end
  end

  assign bus.out_data   = r_out_data_p1;
  assign bus.out_valid  = r_vld_p1;
  assign bus.fifo_used  = w_used;
  assign bus.fifo_full  = w_full;
  assign bus.fifo_empty = w_empty;
  assign bus.underflow  = r_underflow;
  assign bus.overflow   = r_overflow;
  assign bus.low_wm_irq = r_low_wm_irq;

endmodule

// File: tb/tb_audio_fifo_streamer.sv
// -----------------------------------------------------------------------------
// tb_audio_fifo_streamer
// Self-checking bench for audio_fifo_streamer with default parameters.
// Pushed frames are queued as expected output; a monitor pops and compares
// on every out_valid strobe.
// -----------------------------------------------------------------------------
module tb_audio_fifo_streamer;
  import audio_fifo_pkg::*;

  localparam int FW = AFS_NUM_CH * AFS_DATA_W;

  logic clk;
  logic rst;

  audio_fifo_streamer_if bus ();

  audio_fifo_streamer dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int fidx  = 0;
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] mon_exp;

  typedef struct {
    int unsigned div;
    int          period;
  } per_rec_t;
  per_rec_t tbl [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid actual=%0h required=no_strobe", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("frame_order", 64'(bus.out_data), 64'(mon_exp));
      end
    end
  end

  function automatic logic [FW-1:0] frame(input int k);
    return {16'(2 * k + 1), 16'(2 * k + 2)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit track);
    logic [FW-1:0] d;
    d = frame(fidx);
    fidx++;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    if (track) exp_q.push_back(d);
    step();
    bus.wr_req  = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_vld(input int budget, output int steps, output bit got);
    got   = 1'b0;
    steps = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (bus.out_valid) begin
        got   = 1'b1;
        steps = i;
        break;
      end
    end
  endtask

  initial begin
    int  n;
    bit  got;
    int  irq_cnt;
    int  irq_used;

    tbl[0] = '{div: 0,  period: 1};
    tbl[1] = '{div: 1,  period: 1};
    tbl[2] = '{div: 2,  period: 2};
    tbl[3] = '{div: 5,  period: 5};
    tbl[4] = '{div: 10, period: 10};

    bus.wr_data  = '0;
    bus.wr_req   = 1'b0;
    bus.div_freq = 32'd10;
    bus.pause    = 1'b0;
    bus.stop     = 1'b0;
    rst          = 1'b1;
    step();
    step();
    chk("rst_used",      64'(bus.fifo_used),  0);
    chk("rst_empty",     64'(bus.fifo_empty), 1);
    chk("rst_full",      64'(bus.fifo_full),  0);
    chk("rst_out_data",  64'(bus.out_data),   0);
    chk("rst_out_valid", 64'(bus.out_valid),  0);
    chk("rst_underflow", 64'(bus.underflow),  0);
    chk("rst_overflow",  64'(bus.overflow),   0);
    chk("rst_irq",       64'(bus.low_wm_irq), 0);
    rst = 1'b0;

    // Four frames at div 10: start-up latency, steady period, drain to empty.
    for (int i = 0; i < 4; i++) push_frame(1'b1);
    chk("used_after_4", 64'(bus.fifo_used), 4);
    wait_vld(40, n, got);
    chk("first_vld_seen", 64'(got), 1);
    chk("first_latency",  64'(n), 11);
    for (int i = 0; i < 3; i++) begin
      wait_vld(20, n, got);
      chk("run_period", 64'(n), 10);
    end
    chk("empty_after_4th", 64'(bus.fifo_empty), 1);

    // Two more frames play, then starvation.
    push_frame(1'b1);
    push_frame(1'b1);
    wait_vld(20, n, got);
    chk("f5_seen", 64'(got), 1);
    wait_vld(20, n, got);
    chk("f6_period", 64'(n), 10);
    chk("no_underflow_yet", 64'(bus.underflow), 0);
    wait_vld(15, n, got);
    chk("starve_no_vld", 64'(got), 0);
    chk("underflow_set", 64'(bus.underflow), 1);
    chk("out_data_hold", 64'(bus.out_data), 64'(frame(5)));
    push_frame(1'b1);
    wait_vld(15, n, got);
    chk("still_run_after_underflow", 64'(got), 1);
    do_stop();
    chk("stop_clr_underflow", 64'(bus.underflow), 0);
    chk("stop_clr_out_data",  64'(bus.out_data),  0);
    chk("stop_clr_used",      64'(bus.fifo_used), 0);

    // Sample period versus div_freq.
    foreach (tbl[t]) begin
      do_stop();
      bus.div_freq = tbl[t].div;
      for (int i = 0; i < 4; i++) push_frame(1'b1);
      wait_vld(60, n, got);
      chk("tbl_first_vld", 64'(got), 1);
      wait_vld(60, n, got);
      chk($sformatf("tbl_period_div%0d", tbl[t].div), 64'(n), 64'(tbl[t].period));
    end
    do_stop();

    // Fill to capacity while held in IDLE, then one more push.
    bus.pause = 1'b1;
    for (int i = 0; i < 2048; i++) push_frame(1'b0);
    chk("full_used",      64'(bus.fifo_used), 2048);
    chk("full_flag",      64'(bus.fifo_full), 1);
    chk("full_no_ovf",    64'(bus.overflow),  0);
    push_frame(1'b0);
    chk("ovf_set",        64'(bus.overflow),  1);
    chk("ovf_used_held",  64'(bus.fifo_used), 2048);
    chk("ovf_full_held",  64'(bus.fifo_full), 1);
    do_stop();
    chk("stop_clr_ovf",   64'(bus.overflow),  0);
    chk("stop_empty",     64'(bus.fifo_empty), 1);
    chk("stop_not_full",  64'(bus.fifo_full), 0);

    // Pause at divider count 3 for 25 cycles.
    bus.pause    = 1'b0;
    bus.div_freq = 32'd10;
    for (int i = 0; i < 8; i++) push_frame(1'b1);
    wait_vld(40, n, got);
    chk("pause_pre_vld", 64'(got), 1);
    step();
    step();
    step();
    bus.pause = 1'b1;
    wait_vld(25, n, got);
    chk("paused_no_vld", 64'(got), 0);
    bus.pause = 1'b0;
    wait_vld(20, n, got);
    chk("resume_latency", 64'(n), 7);

    // Stop together with wr_req at 300 frames.
    bus.pause = 1'b1;
    for (int g = 0; g < 400 && bus.fifo_used < 300; g++) push_frame(1'b1);
    chk("used_300", 64'(bus.fifo_used), 300);
    bus.wr_data = frame(999);
    bus.wr_req  = 1'b1;
    bus.stop    = 1'b1;
    step();
    bus.wr_req  = 1'b0;
    bus.stop    = 1'b0;
    exp_q.delete();
    chk("stopwr_used",     64'(bus.fifo_used),  0);
    chk("stopwr_ovf",      64'(bus.overflow),   0);
    chk("stopwr_out_data", 64'(bus.out_data),   0);
    chk("stopwr_empty",    64'(bus.fifo_empty), 1);
    // IDLE holds below START_LVL, starts at START_LVL.
    bus.pause = 1'b0;
    for (int i = 0; i < 3; i++) push_frame(1'b1);
    wait_vld(30, n, got);
    chk("idle_below_start", 64'(got), 0);
    push_frame(1'b1);
    wait_vld(30, n, got);
    chk("start_at_lvl", 64'(got), 1);
    do_stop();

    // Drain across the low watermark.
    bus.pause = 1'b1;
    for (int i = 0; i < 257; i++) push_frame(1'b1);
    bus.div_freq = 32'd1;
    bus.pause    = 1'b0;
    irq_cnt  = 0;
    irq_used = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.low_wm_irq) begin
        irq_cnt++;
        irq_used = int'(bus.fifo_used);
      end
      if (bus.fifo_used <= 250) break;
    end
    chk("irq_count",   64'(irq_cnt), 1);
    chk("irq_at_used", 64'(irq_used), 255);
    do_stop();

    // Asynchronous reset in mid-playback.
    bus.div_freq = 32'd3;
    for (int i = 0; i < 6; i++) push_frame(1'b1);
    wait_vld(30, n, got);
    chk("pre_reset_vld", 64'(got), 1);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("async_rst_used",     64'(bus.fifo_used),  0);
    chk("async_rst_empty",    64'(bus.fifo_empty), 1);
    chk("async_rst_out_data", 64'(bus.out_data),   0);
    chk("async_rst_vld",      64'(bus.out_valid),  0);
    step();
    rst = 1'b0;
    wait_vld(20, n, got);
    chk("post_reset_quiet", 64'(got), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_fifo_streamer.md
AUDIO_FIFO_STREAMER -- requirements
Module: audio_fifo_streamer

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 16, bits per channel sample; NUM_CH, 2, channels per frame; DEPTH_LOG2, 11, FIFO depth 2^DEPTH_LOG2 frames; DIV_W, 32, divider width; START_LVL, 4, frames required before playback starts; LOW_WM, 256, low-watermark level.
REQ-002 SHALL have a single clock and an asynchronous, active-high reset, named clk_clk and reset_reset.
REQ-003 clk_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset_reset  in  1  asynchronous active-high reset.
REQ-005 wr_data  in  NUM_CH*DATA_W  one frame, channel 0 in LSBs.
REQ-006 wr_req  in  1  push wr_data this cycle.
REQ-007 div_freq  in  DIV_W  sample period in clk cycles; value 0 is treated as 1.
REQ-008 pause  in  1  level; freezes playback.
REQ-009 stop  in  1  pulse; flushes FIFO and returns to IDLE.
REQ-010 out_data  out  NUM_CH*DATA_W  current output frame.
REQ-011 out_valid  out  1  one-cycle strobe when out_data is updated.
REQ-012 fifo_used  out  DEPTH_LOG2+1  frames stored.
REQ-013 fifo_full / fifo_empty  out  1 each  FIFO status.
REQ-014 underflow / overflow  out  1 each  sticky error flags.
REQ-015 low_wm_irq  out  1  one-cycle interrupt pulse.

Function
REQ-016 States SHALL be IDLE, RUN and PAUSED.
REQ-017 IDLE->RUN SHALL occur when fifo_used >= START_LVL and pause=0.
REQ-018 RUN->PAUSED SHALL occur on pause=1; PAUSED->RUN SHALL occur on pause=0.
REQ-019 stop=1 in any state SHALL take priority: next state IDLE, fifo_used=0, divider=0, out_data=0, underflow/overflow cleared.
REQ-020 Divider SHALL count only in RUN and be held in PAUSED; it SHALL be cleared in IDLE.
REQ-021 A tick SHALL occur when count >= max(div_freq,1)-1, and the count SHALL reset to 0 on that cycle, so a lowered div_freq ticks on the next cycle.
REQ-022 On a tick with FIFO non-empty, the head frame SHALL be popped; out_data SHALL update and out_valid SHALL pulse on the cycle after the tick (1-cycle latency).
REQ-023 On a tick with FIFO empty, out_data SHALL hold its value, out_valid SHALL stay 0, underflow SHALL set, and the state SHALL remain RUN.
REQ-024 A write SHALL be accepted when wr_req=1, fifo_full=0 and stop=0; fifo_used and flags SHALL update on the next cycle.
REQ-025 wr_req while full SHALL drop the frame and set overflow, even if a pop occurs in the same cycle.
REQ-026 Simultaneous accepted push and pop SHALL leave fifo_used unchanged.
REQ-027 Push to an empty FIFO on a tick cycle SHALL NOT satisfy that tick; the tick SHALL be an underflow.
REQ-028 Read and write pointers SHALL wrap modulo 2^DEPTH_LOG2; fifo_used SHALL range 0..2^DEPTH_LOG2.
REQ-029 low_wm_irq SHALL pulse for one cycle when, in RUN, fifo_used goes from >= LOW_WM to < LOW_WM.
REQ-030 stop and wr_req in the same cycle: stop SHALL win and the write SHALL be dropped without setting overflow.

Reset
REQ-031 Reset SHALL force: state IDLE, pointers and divider 0, out_data 0, out_valid 0, fifo_used 0, fifo_empty 1, fifo_full 0, underflow 0, overflow 0, low_wm_irq 0.
REQ-032 Reset asserted mid-playback SHALL take effect immediately and discard all FIFO contents.

Structure
REQ-033 Package audio_fifo_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 Frame storage and pointers SHALL be a sub-module afs_frame_fifo; the FSM, divider and flags SHALL live in the top level.

Verification
REQ-035 Reset; write 4 frames 0x0001_0002..0x0007_0008, div_freq=10 -> RUN, out_valid every 10 cycles, frames emitted in order, fifo_empty after the 4th.
REQ-036 Let 2 frames play, then starve -> underflow=1, out_data holds the last frame, no out_valid pulse.
REQ-037 Fill to 2048, then wr_req again -> fifo_full=1, overflow=1, fifo_used stays 2048.
REQ-038 pause=1 for 25 cycles mid-period at count 3 -> no out_valid while paused; next tick 7 cycles after pause release.
REQ-039 stop asserted together with wr_req at fifo_used=300 -> fifo_used=0, IDLE, out_data=0, overflow=0.
REQ-040 Drain from 257 to 255 with LOW_WM=256 -> exactly one low_wm_irq pulse, on the 256->255 transition.
